// File: rtl/alu_md.sv
// alu_md: RISC-V style ALU with iterative multiply/divide behind a valid/ready handshake.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid / in_ready   request handshake; ctl, a, b are captured on accept
//   kill                  abort whatever is in flight and return to idle
//   out_valid / out_ready result handshake; result holds while out_valid=1
module alu_md #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      ctl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t            state;
    logic [SHW-1:0]    cnt;
    logic [2*XLEN-1:0] acc, acc_nx, prod;
    logic [XLEN-1:0]   opd, short_res, ma, mb, dres, dfin, long_res;
    logic [XLEN:0]     sum, rs, diff;
    logic [SHW-1:0]    sh;
    logic [2:0]        op;
    logic              neg, sa, sb, neg_in, is_long;

    assign in_ready = (state == IDLE) && !reset;
    assign is_long  = ctl[4] && !ctl[3];
    assign sh       = b[SHW-1:0];

    // Long ops run on magnitudes; sa/sb mark which operands are treated as signed.
    assign sa = a[XLEN-1] && (ctl == 5'd17 || ctl == 5'd18 || ctl == 5'd20 || ctl == 5'd22);
    assign sb = b[XLEN-1] && (ctl == 5'd17 || ctl == 5'd20 || ctl == 5'd22);
    assign ma = sa ? -a : a;
    assign mb = sb ? -b : b;
    // Quotient sign is suppressed on divide-by-zero so DIV still yields all ones;
    // remainder sign follows the dividend.
    assign neg_in = !ctl[2] ? sa ^ sb : ctl[1] ? sa : (sa ^ sb) && (b != '0);

    always_comb begin
        short_res = '0;
        case (ctl)
            5'd0:    short_res = a + b;
            5'd1:    short_res = a - b;
            5'd2:    short_res = XLEN'($signed(a) < $signed(b));
            5'd3:    short_res = XLEN'(a < b);
            5'd4:    short_res = a ^ b;
            5'd5:    short_res = a | b;
            5'd6:    short_res = a & b;
            5'd7:    short_res = a << sh;
            5'd8:    short_res = a >> sh;
            5'd9:    short_res = $signed(a) >>> sh;
            default: short_res = '0;
        endcase
    end

    // Multiply: acc = {partial, multiplier}; add opd when lsb set, shift right.
    assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
    // Divide: acc = {remainder, quotient}; shift left, trial-subtract divisor, restore on borrow.
    assign rs     = acc[2*XLEN-1:XLEN-1];
    assign diff   = rs - {1'b0, opd};
    assign acc_nx = op[2] ? (diff[XLEN] ? {rs[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                        : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                          : {sum, acc[XLEN-1:1]};

    assign prod     = neg ? -acc_nx : acc_nx;
    assign dres     = op[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
    assign dfin     = neg ? -dres : dres;
    assign long_res = op[2] ? dfin : (op[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            opd       <= '0;
            op        <= '0;
            neg       <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (kill) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (is_long) begin
                        state <= BUSY;
                        cnt   <= '0;
                        op    <= ctl[2:0];
                        neg   <= neg_in;
                        opd   <= ctl[2] ? mb : ma;
                        acc   <= {{XLEN{1'b0}}, ctl[2] ? ma : mb};
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= short_res;
                    end
                end
                BUSY: begin
                    acc <= acc_nx;
                    cnt <= cnt + SHW'(1);
                    // The final iteration's value feeds the sign fix-up directly.
                    if (cnt == SHW'(XLEN - 1)) begin
                        state     <= DONE;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        result    <= long_res;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: randomized and directed check of alu_md (XLEN 32 and 64) against an arithmetic model.
module tb_alu_md;
    logic        clk = 1'b0, reset = 1'b1, kill = 1'b0, out_ready = 1'b0, iv32 = 1'b0, iv64 = 1'b0;
    logic [4:0]  ctl = '0;
    logic [63:0] a = '0, b = '0;
    logic        rdy32, rdy64, ov32, ov64;
    logic [31:0] res32;
    logic [63:0] res64;
    int          n = 0, errs = 0;

    always #5 clk = ~clk;

    alu_md #(.XLEN(32)) u32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(rdy32), .ctl(ctl),
        .a(a[31:0]), .b(b[31:0]), .kill(kill), .out_valid(ov32), .out_ready(out_ready),
        .result(res32)
    );

    alu_md #(.XLEN(64)) u64 (
        .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(rdy64), .ctl(ctl),
        .a(a), .b(b), .kill(kill), .out_valid(ov64), .out_ready(out_ready),
        .result(res64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy_of(input int w);
        return w == 64 ? rdy64 : rdy32;
    endfunction

    function automatic logic ov_of(input int w);
        return w == 64 ? ov64 : ov32;
    endfunction

    function automatic logic [63:0] res_of(input int w);
        return w == 64 ? res64 : {32'b0, res32};
    endfunction

    function automatic logic [63:0] model(input int w, input logic [4:0] c, input logic [63:0] xi, input logic [63:0] yi);
        logic [63:0]         m, x, y;
        logic signed [127:0] sx, sy, ux, uy, r;
        int                  sh;
        m  = w == 64 ? '1 : 64'hFFFF_FFFF;
        x  = xi & m;
        y  = yi & m;
        sx = w == 64 ? {{64{x[63]}}, x} : {{96{x[31]}}, x[31:0]};
        sy = w == 64 ? {{64{y[63]}}, y} : {{96{y[31]}}, y[31:0]};
        ux = {64'b0, x};
        uy = {64'b0, y};
        sh = int'(y[5:0]) & (w - 1);
        case (c)
            5'd0:    r = ux + uy;
            5'd1:    r = ux - uy;
            5'd2:    r = (sx < sy) ? 1 : 0;
            5'd3:    r = (ux < uy) ? 1 : 0;
            5'd4:    r = ux ^ uy;
            5'd5:    r = ux | uy;
            5'd6:    r = ux & uy;
            5'd7:    r = ux << sh;
            5'd8:    r = ux >> sh;
            5'd9:    r = sx >>> sh;
            5'd16:   r = ux * uy;
            5'd17:   r = (sx * sy) >>> w;
            5'd18:   r = (sx * uy) >>> w;
            5'd19:   r = (ux * uy) >>> w;
            5'd20:   r = y == 0 ? -1 : sx / sy;
            5'd21:   r = y == 0 ? -1 : ux / uy;
            5'd22:   r = y == 0 ? sx : sx % sy;
            5'd23:   r = y == 0 ? ux : ux % uy;
            default: r = 0;
        endcase
        return r[63:0] & m;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = 64'(1) << (w - 1);
            3:       v = 64'($urandom_range(0, 20));
            4:       v = -64'($urandom_range(1, 20));
            default: v = {$urandom, $urandom};
        endcase
        return w == 64 ? v : v & 64'hFFFF_FFFF;
    endfunction

    task automatic run_op(input int w, input logic [4:0] c, input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] exp, input int stall);
        int lat, t, exp_lat;
        exp_lat = (c >= 16 && c <= 23) ? w + 1 : 1;
        t = 0;
        while (!rdy_of(w) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("in_ready before issue", 64'(rdy_of(w)), 1);
        ctl = c;
        a   = x;
        b   = y;
        if (w == 64) iv64 = 1'b1; else iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        iv64 = 1'b0;
        lat  = 1;
        while (!ov_of(w) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency w%0d c%0d", w, c), 64'(lat), 64'(exp_lat));
        chk($sformatf("result w%0d c%0d a=%h b=%h", w, c, x, y), res_of(w), exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("hold out_valid", 64'(ov_of(w)), 1);
            chk("hold result", res_of(w), exp);
            chk("hold in_ready", 64'(rdy_of(w)), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain out_valid", 64'(ov_of(w)), 0);
        chk("drain in_ready", 64'(rdy_of(w)), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0]  c;
        logic [63:0] x, y;
        int          seen;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready32", 64'(rdy32), 0);
        chk("reset in_ready64", 64'(rdy64), 0);
        chk("reset out_valid32", 64'(ov32), 0);
        chk("reset result32", {32'b0, res32}, 0);
        chk("reset result64", res64, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("in_ready after reset", 64'(rdy32), 1);

        run_op(32, 5'd0,  64'hFFFF_FFFF, 64'h1,         64'h0,         0);
        run_op(32, 5'd9,  64'h8000_0000, 64'h21,        64'hC000_0000, 0);
        run_op(32, 5'd19, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 0);
        run_op(32, 5'd17, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0,         0);
        run_op(32, 5'd20, 64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFFD, 0);
        run_op(32, 5'd22, 64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFFF, 0);
        run_op(32, 5'd21, 64'h5,         64'h0,         64'hFFFF_FFFF, 0);
        run_op(32, 5'd23, 64'h5,         64'h0,         64'h5,         0);
        run_op(32, 5'd20, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 0);
        run_op(32, 5'd22, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0,         0);
        run_op(32, 5'd20, 64'hFFFF_FFF9, 64'h0,         64'hFFFF_FFFF, 0);
        run_op(32, 5'd22, 64'hFFFF_FFF9, 64'h0,         64'hFFFF_FFF9, 0);
        run_op(32, 5'd2,  64'h8000_0000, 64'h1,         64'h1,         0);
        run_op(32, 5'd3,  64'h8000_0000, 64'h1,         64'h0,         0);
        run_op(32, 5'd18, 64'hFFFF_FFFF, 64'h2,         64'hFFFF_FFFF, 0);
        run_op(32, 5'd12, 64'h1234,      64'h5678,      64'h0,         0);
        run_op(32, 5'd0,  64'h2,         64'h3,         64'h5,         10);
        run_op(64, 5'd16, 64'h1_0000_0000, 64'h1_0000_0000, 64'h0, 0);
        run_op(64, 5'd19, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1, 0);

        for (int i = 0; i < 150; i++) begin
            c = 5'($urandom_range(0, 31));
            x = pick(32);
            y = pick(32);
            run_op(32, c, x, y, model(32, c, x, y), $urandom_range(0, 2));
        end
        for (int i = 0; i < 40; i++) begin
            c = 5'($urandom_range(0, 31));
            x = pick(64);
            y = pick(64);
            run_op(64, c, x, y, model(64, c, x, y), $urandom_range(0, 2));
        end

        // kill in the middle of a DIVU
        ctl = 5'd21; a = 64'd100; b = 64'd7; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill busy in_ready", 64'(rdy32), 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ov32) seen++;
        end
        chk("kill busy no out_valid", 64'(seen), 0);
        run_op(32, 5'd0, 64'd2, 64'd3, 64'd5, 0);

        // kill blocks an accept in IDLE
        ctl = 5'd0; a = 64'd1; b = 64'd1; iv32 = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0; kill = 1'b0;
        chk("kill idle out_valid", 64'(ov32), 0);
        chk("kill idle in_ready", 64'(rdy32), 1);

        // kill while a result waits in DONE
        ctl = 5'd0; a = 64'd7; b = 64'd8; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        chk("pre-kill done out_valid", 64'(ov32), 1);
        out_ready = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; kill = 1'b0;
        chk("kill done out_valid", 64'(ov32), 0);
        chk("kill done in_ready", 64'(rdy32), 1);

        // reset pulse mid-BUSY on both widths
        ctl = 5'd19; a = 64'h1_0000_0000; b = 64'h1_0000_0000; iv32 = 1'b1; iv64 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0; iv64 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset mid-busy in_ready", 64'(rdy64), 0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (ov32 || ov64) seen++;
        end
        chk("reset mid-busy no out_valid", 64'(seen), 0);
        chk("reset mid-busy idle", 64'(rdy64), 1);
        run_op(64, 5'd16, 64'h1_0000_0000, 64'h1_0000_0000, 64'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width; not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 ctl  input  5  operation select, sampled on accept.
REQ-008 a, b  input  XLEN each  operands, sampled on accept.
REQ-009 kill  input  1  abort any in-flight operation.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  XLEN  registered result; stable while out_valid=1.

Function
REQ-013 ctl encoding SHALL be: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; any other code SHALL be a short op with result 0.
REQ-014 FSM SHALL have states IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-015 Accept = in_valid & in_ready; ctl, a, b SHALL be captured at accept.
REQ-016 Short ops (ctl<16 or unknown): IDLE->DONE on accept; out_valid asserted the cycle after accept (latency 1).
REQ-017 Long ops (16..23): IDLE->BUSY on accept; exactly XLEN iteration cycles in BUSY (counter 0..XLEN-1); BUSY->DONE after the last iteration; out_valid asserted XLEN+1 cycles after accept.
REQ-018 DONE: out_valid=1; DONE->IDLE on out_ready=1; result and out_valid SHALL hold unchanged while out_ready=0.
REQ-019 Arithmetic SHALL be modulo 2^XLEN; SLT/SLTU result SHALL be zero-extended 0/1.
REQ-020 Shifts SHALL use b[SHW-1:0] only; SRA SHALL replicate a[XLEN-1].
REQ-021 MUL SHALL return low XLEN bits of product; MULH signed x signed, MULHSU signed a x unsigned b, MULHU unsigned x unsigned, each SHALL return high XLEN bits.
REQ-022 Multiply SHALL be radix-2 shift-add over 2*XLEN-bit accumulator; divide SHALL be radix-2 restoring on magnitudes with sign fix-up in the DONE transition.
REQ-023 Divide by zero: DIV/DIVU quotient SHALL be all ones; REM/REMU SHALL return a.
REQ-024 Signed overflow (a=-2^(XLEN-1), b=-1): DIV SHALL return a; REM SHALL return 0.
REQ-025 DIV/REM SHALL truncate toward zero; remainder sign SHALL follow dividend.
REQ-026 kill=1 SHALL force IDLE next cycle from any state, clearing out_valid and discarding the result; kill=1 in IDLE with in_valid=1 SHALL block the accept.
REQ-027 kill has priority over out_ready; reset has priority over kill.
REQ-028 No new request SHALL be accepted in the same cycle DONE->IDLE occurs (one idle cycle between results).

Reset
REQ-029 reset=1 SHALL force state=IDLE, counter=0, out_valid=0, result=0, internal accumulators=0.
REQ-030 in_ready SHALL be 0 while reset=1 and 1 on the first cycle after reset deasserts.
REQ-031 Reset mid-BUSY or mid-DONE SHALL abandon the operation with no out_valid pulse.

Verification
REQ-032 ADD a=0xFFFFFFFF b=1 (XLEN=32) -> out_valid 1 cycle after accept, result 0x00000000; SRA a=0x80000000 b=0x21 -> 0xC0000000.
REQ-033 MULHU a=b=0xFFFFFFFF -> out_valid exactly 33 cycles after accept, result 0xFFFFFFFE; MULH a=-1 b=-1 -> 0x00000000.
REQ-034 DIV a=-7 b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU a=5 b=0 -> 0xFFFFFFFF; REMU -> 5; DIV 0x80000000 / -1 -> 0x80000000, REM -> 0.
REQ-035 Backpressure: out_ready=0 for 10 cycles in DONE -> result, out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-036 kill asserted on iteration 5 of DIVU -> IDLE next cycle, no out_valid; following ADD 2+3 -> 5.
REQ-037 XLEN=64: MUL a=2^32 b=2^32 -> 0, MULHU -> 1, latency 65 cycles; reset pulse mid-BUSY -> out_valid stays 0.
